// File: rtl/pio_2401_dr.sv
// ---------------------------------------------------------------------------
// pio_2401_dr
//   Memory-mapped input port for the two nRF2401 data-ready pins (DR1/DR2).
//   Each pin is synchronised, glitch-filtered with a programmable length,
//   and its filtered rising edges are captured into a write-1-to-clear
//   register that can raise a maskable level interrupt.
//
// Ports
//   clk        : single clock for all logic
//   reset_n    : asynchronous active-low reset
//   address    : register select (0 data, 1 filt_len, 2 irqmask, 3 edgecap)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   in_port    : asynchronous DR1/DR2 pins
//   readdata   : zero-latency read data (combinational from address)
//   irq        : level interrupt, OR of (edgecap & irqmask)
// ---------------------------------------------------------------------------
module pio_2401_dr #(
  parameter logic [3:0] FILT_RST = 4'd3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] address,
  input  logic       chipselect,
  input  logic       write_n,
  input  logic [3:0] writedata,
  input  logic [1:0] in_port,
  output logic [3:0] readdata,
  output logic       irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_FILTLEN = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [1:0]      sync1_r;
  logic [1:0]      sync2_r;
  logic [1:0][3:0] cnt_r;
  logic [1:0][3:0] cnt_nxt_s;
  logic [1:0]      filt_r;
  logic [1:0]      filt_nxt_s;
  logic [1:0]      rise_s;
  logic [3:0]      filt_len_r;
  logic [1:0]      irqmask_r;
  logic [1:0]      edgecap_r;
  logic [1:0]      edgecap_nxt_s;
  logic            wr_en_s;

  // Write-1-to-clear update where a simultaneous set wins over the clear.
  function automatic logic [1:0] w1c_update(input logic [1:0] cur,
                                            input logic [1:0] set,
                                            input logic [1:0] clr,
                                            input logic       clr_en);
    logic [1:0] clr_mask;
    clr_mask = clr & {2{clr_en}};
    return (cur & ~clr_mask) | set;
  endfunction

  assign wr_en_s = chipselect & ~write_n;

  // Two-flop synchroniser for the asynchronous pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= in_port;
      sync2_r <= sync1_r;
    end
  end

  // Per-bit glitch filter next state. A differing level must persist until
  // cnt reaches filt_len before filt follows it; any return to the filtered
  // level clears cnt. A cnt already above a newly lowered filt_len simply
  // keeps counting and wraps, no update is forced.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    filt_nxt_s = filt_r;
    for (int i = 0; i < 2; i++) begin
      if (sync2_r[i] == filt_r[i]) begin
        cnt_nxt_s[i] = 4'd0;
      end else if (cnt_r[i] == filt_len_r) begin
        filt_nxt_s[i] = sync2_r[i];
        cnt_nxt_s[i]  = 4'd0;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + 4'd1;
      end
    end
  end

  // Only filtered 0->1 transitions are captured.
  assign rise_s = filt_nxt_s & ~filt_r;

  // Edge-capture next state: rising edges set, W1C writes to address 3 clear.
  always_comb begin
    edgecap_nxt_s = w1c_update(edgecap_r, rise_s, writedata[1:0],
                               wr_en_s && (address == ADDR_EDGECAP));
  end

  // Filter counters and filtered values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r  <= '0;
      filt_r <= 2'b00;
    end else begin
      cnt_r  <= cnt_nxt_s;
      filt_r <= filt_nxt_s;
    end
  end

  // Software-visible control registers and the edge-capture register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_len_r <= FILT_RST;
      irqmask_r  <= 2'b00;
      edgecap_r  <= 2'b00;
    end else begin
      edgecap_r <= edgecap_nxt_s;
      if (wr_en_s && (address == ADDR_FILTLEN)) begin
        filt_len_r <= writedata;
      end else begin
        filt_len_r <= filt_len_r;
      end
      if (wr_en_s && (address == ADDR_IRQMASK)) begin
        irqmask_r <= writedata[1:0];
      end else begin
        irqmask_r <= irqmask_r;
      end
    end
  end

  // Zero-latency read mux, independent of chipselect/write_n.
  always_comb begin
    readdata = 4'h0;
    case (address)
      ADDR_DATA:    readdata = {2'b00, filt_r};
      ADDR_FILTLEN: readdata = filt_len_r;
      ADDR_IRQMASK: readdata = {2'b00, irqmask_r};
      ADDR_EDGECAP: readdata = {2'b00, edgecap_r};
      default:      readdata = 4'h0;
    endcase
  end

  assign irq = |(edgecap_r & irqmask_r);

endmodule

// File: tb/tb_pio_2401_dr.sv
// ---------------------------------------------------------------------------
// tb_pio_2401_dr
//   Directed bench for pio_2401_dr. Each read issued by the stimulus pushes
//   its hand-computed readdata/irq into a queue; the monitor pops and
//   compares on every read access (chipselect=1, write_n=1) at the falling
//   clock edge.
// ---------------------------------------------------------------------------
module tb_pio_2401_dr;

  logic       clk;
  logic       reset_n;
  logic [1:0] address;
  logic       chipselect;
  logic       write_n;
  logic [3:0] writedata;
  logic [1:0] in_port;
  logic [3:0] readdata;
  logic       irq;

  typedef struct {
    logic [3:0]  rd;
    logic        irq;
    logic [95:0] name;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  pio_2401_dr #(.FILT_RST(4'd3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bus cycle: drive just after the rising edge.
  task automatic step(input logic cs, input logic wn, input logic [1:0] a,
                      input logic [3:0] d);
    @(posedge clk);
    #1;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;
  endtask

  task automatic rd(input logic [1:0] a, input logic [3:0] ed, input logic ei,
                    input logic [95:0] nm);
    exp_t e;
    e.rd   = ed;
    e.irq  = ei;
    e.name = nm;
    exp_q.push_back(e);
    step(1'b1, 1'b1, a, 4'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] d);
    step(1'b1, 1'b0, a, d);
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 2'd0, 4'h0);
  endtask

  // Monitor: compare every read access against the scoreboard head.
  always @(negedge clk) begin
    if (chipselect && write_n) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL no_expect: read at addr %0d with readdata=%h irq=%b but no expected entry",
                 address, readdata, irq);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (readdata !== e.rd || irq !== e.irq) begin
          $display("FAIL %0s: got readdata=%h irq=%b, expected readdata=%h irq=%b",
                   e.name, readdata, irq, e.rd, e.irq);
        end else begin
          pass_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 4'h0;
    in_port    = 2'b00;

    // Reset state
    rd(2'd1, 4'h3, 1'b0, "rst_flen");
    rd(2'd0, 4'h0, 1'b0, "rst_data");
    rd(2'd2, 4'h0, 1'b0, "rst_mask");
    rd(2'd3, 4'h0, 1'b0, "rst_edge");
    reset_n = 1'b1;

    // Filter delay: bit 0 rises, filt_len=3 -> visible 6 edges later
    rd(2'd0, 4'h0, 1'b0, "s1_pre");
    in_port = 2'b01;
    for (int k = 0; k < 5; k++) rd(2'd0, 4'h0, 1'b0, "s1_wait");
    rd(2'd0, 4'h1, 1'b0, "s1_rise");
    rd(2'd3, 4'h1, 1'b0, "s1_cap");

    // Unmask a pending bit, W1C of other bit, W1C of own bit
    wr(2'd2, 4'h1);
    rd(2'd2, 4'h1, 1'b1, "unmask_irq");
    wr(2'd3, 4'h2);
    rd(2'd3, 4'h1, 1'b1, "w1c_other");
    wr(2'd3, 4'h1);
    rd(2'd3, 4'h0, 1'b0, "w1c_clear");
    wr(2'd0, 4'hF);
    rd(2'd0, 4'h1, 1'b0, "data_ro");

    // Glitch rejection: 3-cycle pulse on bit 1
    in_port = 2'b11;
    for (int k = 0; k < 3; k++) rd(2'd0, 4'h1, 1'b0, "gl_pulse");
    in_port = 2'b01;
    for (int k = 0; k < 6; k++) rd(2'd0, 4'h1, 1'b0, "gl_after");
    rd(2'd3, 4'h0, 1'b0, "gl_cap");

    // Masked capture on bit 1, then unmask
    wr(2'd2, 4'h0);
    rd(2'd2, 4'h0, 1'b0, "mask_off");
    in_port = 2'b11;
    for (int k = 0; k < 5; k++) rd(2'd0, 4'h1, 1'b0, "m_wait");
    rd(2'd0, 4'h3, 1'b0, "m_rise");
    rd(2'd3, 4'h2, 1'b0, "m_cap");
    wr(2'd2, 4'h2);
    rd(2'd2, 4'h2, 1'b1, "m_unmask");
    wr(2'd3, 4'h2);
    rd(2'd3, 4'h0, 1'b0, "m_clr");

    // Falling edge does not capture
    in_port = 2'b10;
    for (int k = 0; k < 8; k++) idle();
    rd(2'd0, 4'h2, 1'b0, "fall");
    rd(2'd3, 4'h0, 1'b0, "fall_nocap");

    // Set/clear collision on bit 0
    wr(2'd2, 4'h1);
    rd(2'd2, 4'h1, 1'b0, "col_mask");
    in_port = 2'b11;
    for (int k = 0; k < 4; k++) rd(2'd0, 4'h2, 1'b0, "col_wait");
    wr(2'd3, 4'h1);
    rd(2'd3, 4'h1, 1'b1, "collide");
    wr(2'd3, 4'h1);
    rd(2'd3, 4'h0, 1'b0, "col_clr");

    // filt_len=0: filt follows one edge after sync output changes
    wr(2'd1, 4'h0);
    rd(2'd1, 4'h0, 1'b0, "flen0");
    in_port = 2'b01;
    rd(2'd0, 4'h3, 1'b0, "n0_hold1");
    rd(2'd0, 4'h3, 1'b0, "n0_hold2");
    rd(2'd0, 4'h1, 1'b0, "n0_fall");
    wr(2'd2, 4'hE);
    rd(2'd2, 4'h2, 1'b0, "mask_hi");
    wr(2'd2, 4'h0);

    // Mid-filter reset with input held high
    wr(2'd1, 4'h7);
    rd(2'd1, 4'h7, 1'b0, "flen7");
    in_port = 2'b00;
    for (int k = 0; k < 12; k++) idle();
    rd(2'd0, 4'h0, 1'b0, "pre_rst_low");
    in_port = 2'b01;
    for (int k = 0; k < 4; k++) idle();
    reset_n = 1'b0;
    rd(2'd1, 4'h3, 1'b0, "mid_rst_flen");
    rd(2'd3, 4'h0, 1'b0, "mid_rst_cap");
    rd(2'd0, 4'h0, 1'b0, "mid_rst_data");
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) rd(2'd0, 4'h0, 1'b0, "post_rst_wait");
    rd(2'd0, 4'h1, 1'b0, "post_rst_rise");
    rd(2'd3, 4'h1, 1'b0, "post_rst_cap");
    wr(2'd2, 4'h1);
    rd(2'd2, 4'h1, 1'b1, "post_rst_irq");
    idle();
    idle();

    total_cnt++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end else begin
      pass_cnt++;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pio_2401_dr.md
PIO_2401_DR -- requirements
Module: pio_2401_dr

Interface
REQ-001 SHALL have parameter FILT_RST, default 3, giving the reset value of the glitch-filter length register.
REQ-002 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port address, input, 2 bits: register select.
REQ-005 SHALL have port chipselect, input, 1 bit: slave select.
REQ-006 SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-007 SHALL have port writedata, input, 4 bits: write data.
REQ-008 SHALL have port in_port, input, 2 bits: asynchronous nRF2401 DR1/DR2 data-ready pins.
REQ-009 SHALL have port readdata, output, 4 bits: read data, zero read latency.
REQ-010 SHALL have port irq, output, 1 bit: level interrupt request.

Function
REQ-011 SHALL implement this register map:
- 0: data; RO; [1:0] = filtered inputs; [3:2] = 0; writes ignored.
- 1: filt_len; RW; [3:0].
- 2: irqmask; RW; [1:0]; [3:2] read 0.
- 3: edgecap; R/W1C; [1:0]; [3:2] read 0.
REQ-012 SHALL perform a write when chipselect=1 and write_n=0 at a rising clk edge, with the effect visible the next cycle.
REQ-013 SHALL drive readdata combinationally from address and the current register state, independent of chipselect and write_n.
REQ-014 SHALL pass each in_port bit through a 2-flop synchronizer (sync) before any other use.
REQ-015 SHALL keep, per bit, a 4-bit counter cnt and a filtered value filt, updated each cycle:
- sync==filt: cnt <= 0.
- sync!=filt and cnt==filt_len: filt <= sync, cnt <= 0.
- otherwise: cnt <= cnt+1.
REQ-016 SHALL update filt N+1 clocks after the new level first appears at the sync output, where N = filt_len (N+3 clocks after in_port settles); N=0 gives 1 clock.
REQ-017 SHALL clear cnt before the filt update whenever an input pulse is shorter than the threshold, so filt never changes on such a pulse.
REQ-018 SHALL apply a filt_len write from the next cycle; an in-flight cnt greater than the new filt_len SHALL keep counting until it wraps at 15->0, with no update forced.
REQ-019 SHALL set edgecap[i] on the same edge at which filt[i] goes 0->1; falling edges SHALL NOT set it.
REQ-020 SHALL clear edgecap[i] on a write to address 3 with writedata[i]=1; writedata bits equal to 0 SHALL leave the corresponding bits unchanged.
REQ-021 SHALL give set priority over clear when both occur on the same edge for the same bit (edgecap[i] stays 1).
REQ-022 SHALL drive irq combinationally as the OR over i of (edgecap[i] AND irqmask[i]).
REQ-023 SHALL keep edgecap bits capturing while masked, so that unmasking a pending bit raises irq on the cycle after the mask write.

Reset
REQ-024 SHALL, while reset_n=0, asynchronously force sync flops=0, cnt=0, filt=0, irqmask=0, edgecap=0, filt_len=FILT_RST, giving irq=0 and readdata at address 0 = 0.
REQ-025 SHALL, on a mid-filter reset, discard any pending transition; after release, an input held high is re-filtered from cnt=0 and SHALL set edgecap (filt rises from 0).
REQ-026 SHALL, on reset release, start sampling at the first rising clk edge with reset_n=1.

Verification
REQ-027 SHALL cover filter delay: filt_len=3, in_port[0] steps 0->1 and holds -> data[0]=1 and edgecap[0]=1 exactly 6 clocks after the sampling edge.
REQ-028 SHALL cover glitch rejection: filt_len=3, 3-cycle high pulse on in_port[1] -> data[1] stays 0, edgecap stays 0, irq stays 0.
REQ-029 SHALL cover interrupt flow: irqmask=2'b01, rising edge on bit 0 -> irq=1; write 4'b0001 to address 3 -> irq=0 next cycle; write 4'b0010 alone leaves edgecap[0] unchanged.
REQ-030 SHALL cover set/clear collision: W1C of bit 0 on the same edge that filt[0] rises -> edgecap[0]=1 and irq remains asserted.
REQ-031 SHALL cover masked capture: irqmask=0, edge on bit 1 -> irq=0 and edgecap=4'b0010; write irqmask=4'b0010 -> irq=1 next cycle.
REQ-032 SHALL cover reset: assert reset_n mid-filter (cnt=2), release with input high -> filt_len reads 3, edgecap reads 0 during reset, then bit sets 6 clocks after the first sampling edge.
